// File: rtl/seq_mul32_shift_add.sv
// Sequential unsigned 32x32 -> 64-bit shift-and-add multiplier built around one
// FADDER32 ripple adder; start/busy/done handshake, one result every 34 cycles.

module FADDER32 (
    output logic        c,
    output logic [31:0] s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin
);

    always_comb begin : ripple
        logic carry;
        carry = cin;
        s     = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c = carry;
    end

endmodule

module seq_mul32_shift_add #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   p_hi_q;
    logic [WIDTH-1:0]   p_lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    logic               add_c;
    logic [WIDTH-1:0]   add_s;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] p_d;
    logic [CNT_W-1:0]   cnt_d;

    always_comb begin
        addend = p_lo_q[0] ? m_q : '0;
    end

    FADDER32 u_add (
        .c   (add_c),
        .s   (add_s),
        .a   (p_hi_q),
        .b   (addend),
        .cin (1'b0)
    );

    // Carry-out lands in P_hi[31] after the shift, so no product bit is lost.
    always_comb begin
        p_d   = {add_c, add_s, p_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= A;
                        p_hi_q  <= '0;
                        p_lo_q  <= B;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    p_hi_q <= p_d[2*WIDTH-1:WIDTH];
                    p_lo_q <= p_d[WIDTH-1:0];
                    cnt_q  <= cnt_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = {p_hi_q, p_lo_q};

endmodule

// File: tb/tb_seq_mul32_shift_add.sv
// Directed bench for seq_mul32_shift_add: handshake timing, products, reset abort.

module tb_seq_mul32_shift_add;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks   = 0;
    int failures = 0;

    seq_mul32_shift_add #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch a job and check busy length, done pulse position and the product.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string tag);
        int bc;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);            // E0
        #1;
        start = 1'b0;
        A = ~a; B = ~b;            // operands must already be captured
        chk({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
        bc = 1;
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (done) bc += 100;
        end
        chk({tag, "_busy_cycles"}, 64'(bc), 64'd32);
        @(posedge clk); #1;        // E32
        chk({tag, "_done_e32"}, {62'd0, busy, done}, 64'd1);
        chk({tag, "_product"}, product, exp);
        @(posedge clk); #1;        // E33
        chk({tag, "_done_e33"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_product_hold"}, product, exp);
    endtask

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {busy, done, product}, 66'd0);

        run_job(32'd3, 32'd5, 64'd15, "t2_3x5");

        // Asynchronous reset in idle clears the held product before any edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("t1_async_reset", {busy, done, product}, 66'd0);
        #1 reset = 1'b0;

        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "t3_max");
        run_job(32'hF000_0000, 32'h0000_0007, 64'h0000_0006_9000_0000, "t4_hi");
        run_job(32'hDEAD_BEEF, 32'h0000_0000, 64'd0, "t5_b0");

        // start held high; operands change during CALC.
        @(negedge clk);
        A = 32'd2; B = 32'd3; start = 1'b1;
        @(posedge clk); #1;        // E0
        A = 32'd100; B = 32'd100;
        repeat (32) @(posedge clk);
        #1;                        // E32
        chk("t6_done", {62'd0, busy, done}, 64'd1);
        chk("t6_product", product, 64'd6);
        @(posedge clk); #1;        // E33: start ignored in DONE
        chk("t6_e33_idle", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;        // E34: second job accepted
        chk("t6_e34_accept", {63'd0, busy}, 64'd1);
        start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        chk("t6_job2_done", {62'd0, busy, done}, 64'd1);
        chk("t6_job2_product", product, 64'd10000);
        @(posedge clk); #1;

        // Reset in the middle of CALC aborts without a done pulse.
        @(negedge clk);
        A = 32'd11; B = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("t7_abort", {busy, done, product}, 66'd0);
        @(negedge clk) reset = 1'b0;
        dc = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        chk("t7_no_done", 64'(dc), 64'd0);
        run_job(32'd7, 32'd9, 64'd63, "t7_7x9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
